// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one external memory bus between the instruction-fetch port (if_*)
// and the data port (dm_*). Requesters are scheduled round-robin, one bus
// transaction runs at a time, and every bus-side and completion output is
// registered. A per-transaction counter aborts any transaction the slave
// never acknowledges.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack)
//   if_rdata/if_ack     fetched word and one-cycle completion pulse
//   stallreq_if         fetch port waiting (if_req & ~if_ack)
//   dm_req/dm_we/dm_sel/dm_addr/dm_wdata   data request and qualifiers
//   dm_rdata/dm_ack     load data and one-cycle completion pulse
//   stallreq_mem        data port waiting (dm_req & ~dm_ack)
//   bus_cyc/bus_stb/bus_we/bus_sel/bus_addr/bus_wdata   master bus outputs
//   bus_rdata/bus_ack   slave read data and completion
//   timeout_o           one-cycle pulse when a transaction is aborted
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        stallreq_if,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_sel,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        stallreq_mem,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    // Counter limit; the counter is 8 bits wide so the parameter is 1..255.
    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = IF, 1 = DM
    logic [7:0]  cnt_q, cnt_d;

    logic        bus_stb_q, bus_stb_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        dm_ack_q, dm_ack_d;
    logic        timeout_q, timeout_d;

    logic        grant_if_s;
    logic        grant_dm_s;
    logic        done_s;       // slave acknowledged the active transaction
    logic        abort_s;      // counter expired without an acknowledge
    logic [7:0]  cnt_inc_s;

    assign cnt_inc_s = cnt_q + 8'd1;

    // State register plus all registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            cnt_q        <= 8'd0;
            bus_stb_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= 4'd0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            if_rdata_q   <= 32'd0;
            dm_rdata_q   <= 32'd0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            bus_stb_q    <= bus_stb_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic: round-robin arbitration in IDLE, completion/timeout in BUSY.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        grant_if_s   = 1'b0;
        grant_dm_s   = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time gets the bus.
                if (if_req && dm_req) begin
                    if (last_grant_q) begin
                        grant_if_s = 1'b1;
                    end else begin
                        grant_dm_s = 1'b1;
                    end
                end else if (if_req) begin
                    grant_if_s = 1'b1;
                end else if (dm_req) begin
                    grant_dm_s = 1'b1;
                end else begin
                    grant_if_s = 1'b0;
                end
                if (grant_if_s) begin
                    state_d      = BUSY_IF;
                    last_grant_d = 1'b0;
                    cnt_d        = 8'd0;
                end else if (grant_dm_s) begin
                    state_d      = BUSY_DM;
                    last_grant_d = 1'b1;
                    cnt_d        = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // An acknowledge in the final allowed cycle still completes normally.
                if (bus_ack && bus_stb_q) begin
                    done_s  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_inc_s == TIMEOUT_LIM) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output logic: load bus on grant, capture data and pulse acks on completion.
    always_comb begin
        bus_stb_d   = bus_stb_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        timeout_d   = 1'b0;
        if (grant_if_s) begin
            bus_stb_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_sel_d   = 4'b1111;
            bus_addr_d  = if_addr;
            bus_wdata_d = 32'd0;
        end else if (grant_dm_s) begin
            bus_stb_d   = 1'b1;
            bus_we_d    = dm_we;
            bus_sel_d   = dm_sel;
            bus_addr_d  = dm_addr;
            bus_wdata_d = dm_wdata;
        end else if (done_s || abort_s) begin
            bus_stb_d = 1'b0;
            timeout_d = abort_s;
            // Aborts and writes return zero so stale bus data never leaks out.
            if (state_q == BUSY_IF) begin
                if_ack_d = 1'b1;
                if (abort_s || bus_we_q) begin
                    if_rdata_d = 32'd0;
                end else begin
                    if_rdata_d = bus_rdata;
                end
            end else begin
                dm_ack_d = 1'b1;
                if (abort_s || bus_we_q) begin
                    dm_rdata_d = 32'd0;
                end else begin
                    dm_rdata_d = bus_rdata;
                end
            end
        end else begin
            bus_stb_d = bus_stb_q;
        end
    end

    assign bus_cyc      = bus_stb_q;
    assign bus_stb      = bus_stb_q;
    assign bus_we       = bus_we_q;
    assign bus_sel      = bus_sel_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign if_ack       = if_ack_q;
    assign dm_ack       = dm_ack_q;
    assign timeout_o    = timeout_q;
    // Stall requests fall in the same cycle as the registered ack pulse.
    assign stallreq_if  = if_req & ~if_ack_q;
    assign stallreq_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter built with TIMEOUT_CYCLES=4. Inputs are
// driven right after a rising edge, and outputs are checked 1 time unit after
// the edge, so every check sees the settled value for the current cycle.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        stallreq_if;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stallreq_mem;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ack       (if_ack),
        .stallreq_if  (stallreq_if),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_sel       (dm_sel),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ack       (dm_ack),
        .stallreq_mem (stallreq_mem),
        .bus_cyc      (bus_cyc),
        .bus_stb      (bus_stb),
        .bus_we       (bus_we),
        .bus_sel      (bus_sel),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .timeout_o    (timeout_o)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_sel    = 4'd0;
        dm_addr   = 32'd0;
        dm_wdata  = 32'd0;
        bus_rdata = 32'd0;
        bus_ack   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_stb",     32'(bus_stb),   32'd0);
        chk("rst_cyc",     32'(bus_cyc),   32'd0);
        chk("rst_we",      32'(bus_we),    32'd0);
        chk("rst_sel",     32'(bus_sel),   32'd0);
        chk("rst_addr",    bus_addr,       32'd0);
        chk("rst_wdata",   bus_wdata,      32'd0);
        chk("rst_if_rd",   if_rdata,       32'd0);
        chk("rst_dm_rd",   dm_rdata,       32'd0);
        chk("rst_if_ack",  32'(if_ack),    32'd0);
        chk("rst_dm_ack",  32'(dm_ack),    32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        rst = 1'b0;

        // IF read, slave acks immediately
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        #1;
        chk("t1_c0_stall_if", 32'(stallreq_if), 32'd1);
        tick();
        chk("t1_c1_stb",      32'(bus_stb),     32'd1);
        chk("t1_c1_cyc",      32'(bus_cyc),     32'd1);
        chk("t1_c1_addr",     bus_addr,         32'h0000_0004);
        chk("t1_c1_sel",      32'(bus_sel),     32'hF);
        chk("t1_c1_we",       32'(bus_we),      32'd0);
        chk("t1_c1_stall_if", 32'(stallreq_if), 32'd1);
        chk("t1_c1_if_ack",   32'(if_ack),      32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h3401_1100;
        tick();
        chk("t1_c2_if_ack",   32'(if_ack),      32'd1);
        chk("t1_c2_if_rd",    if_rdata,         32'h3401_1100);
        chk("t1_c2_stall_if", 32'(stallreq_if), 32'd0);
        chk("t1_c2_stb",      32'(bus_stb),     32'd0);
        if_req    = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        tick();
        chk("t1_c3_if_ack",   32'(if_ack),      32'd0);
        chk("t1_c3_if_hold",  if_rdata,         32'h3401_1100);

        // DM write with 3 wait cycles (4 strobe cycles)
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_sel   = 4'b0011;
        dm_addr  = 32'h0000_0100;
        dm_wdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t2_stb",       32'(bus_stb),      32'd1);
            chk("t2_we",        32'(bus_we),       32'd1);
            chk("t2_sel",       32'(bus_sel),      32'h3);
            chk("t2_addr",      bus_addr,          32'h0000_0100);
            chk("t2_wdata",     bus_wdata,         32'hDEAD_BEEF);
            chk("t2_dm_ack",    32'(dm_ack),       32'd0);
            chk("t2_stall_mem", 32'(stallreq_mem), 32'd1);
            if (i == 4) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'hFFFF_FFFF;
            end
        end
        tick();
        chk("t2_ack",       32'(dm_ack),       32'd1);
        chk("t2_rdata",     dm_rdata,          32'd0);
        chk("t2_stb_off",   32'(bus_stb),      32'd0);
        chk("t2_stall_off", 32'(stallreq_mem), 32'd0);
        chk("t2_no_to",     32'(timeout_o),    32'd0);
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        bus_ack = 1'b0;
        tick();

        // Simultaneous requests from reset, both held: DM, IF, DM
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0040;
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_sel    = 4'hF;
        dm_addr   = 32'h0000_0200;
        bus_ack   = 1'b1;
        bus_rdata = 32'hA5A5_0001;
        tick();
        chk("t3_g1_stb",   32'(bus_stb), 32'd1);
        chk("t3_g1_addr",  bus_addr,     32'h0000_0200);
        tick();
        chk("t3_gap1_stb", 32'(bus_stb), 32'd0);
        chk("t3_dm_ack1",  32'(dm_ack),  32'd1);
        chk("t3_dm_rd1",   dm_rdata,     32'hA5A5_0001);
        chk("t3_if_ack0",  32'(if_ack),  32'd0);
        tick();
        chk("t3_g2_stb",   32'(bus_stb), 32'd1);
        chk("t3_g2_addr",  bus_addr,     32'h0000_0040);
        chk("t3_g2_sel",   32'(bus_sel), 32'hF);
        tick();
        chk("t3_gap2_stb", 32'(bus_stb), 32'd0);
        chk("t3_if_ack",   32'(if_ack),  32'd1);
        chk("t3_if_rd",    if_rdata,     32'hA5A5_0001);
        tick();
        chk("t3_g3_stb",   32'(bus_stb), 32'd1);
        chk("t3_g3_addr",  bus_addr,     32'h0000_0200);
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        chk("t3_dm_ack3",  32'(dm_ack),  32'd1);
        // bus_ack still high while idle must be ignored
        tick();
        chk("t3_idle_stb", 32'(bus_stb), 32'd0);
        chk("t3_idle_ack", 32'(dm_ack),  32'd0);
        chk("t3_idle_ifa", 32'(if_ack),  32'd0);
        bus_ack = 1'b0;

        // Timeout with bus_ack tied low
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t4_stb",    32'(bus_stb),   32'd1);
            chk("t4_ack",    32'(if_ack),    32'd0);
            chk("t4_to",     32'(timeout_o), 32'd0);
        end
        tick();
        chk("t4_stb_off",  32'(bus_stb),     32'd0);
        chk("t4_if_ack",   32'(if_ack),      32'd1);
        chk("t4_timeout",  32'(timeout_o),   32'd1);
        chk("t4_if_rd",    if_rdata,         32'd0);
        chk("t4_stall",    32'(stallreq_if), 32'd0);
        if_req = 1'b0;
        tick();
        chk("t4_to_once",  32'(timeout_o),   32'd0);
        chk("t4_ack_once", 32'(if_ack),      32'd0);
        chk("t4_idle",     32'(bus_stb),     32'd0);

        // Reset in the second BUSY_DM cycle while the slave acks
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_sel  = 4'h5;
        dm_addr = 32'h0000_0300;
        tick();
        chk("t5_c1_stb", 32'(bus_stb), 32'd1);
        tick();
        chk("t5_c2_stb", 32'(bus_stb), 32'd1);
        rst       = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        chk("t5_stb",    32'(bus_stb),   32'd0);
        chk("t5_cyc",    32'(bus_cyc),   32'd0);
        chk("t5_dm_ack", 32'(dm_ack),    32'd0);
        chk("t5_to",     32'(timeout_o), 32'd0);
        chk("t5_addr",   bus_addr,       32'd0);
        chk("t5_sel",    32'(bus_sel),   32'd0);
        chk("t5_dm_rd",  dm_rdata,       32'd0);
        chk("t5_if_rd",  if_rdata,       32'd0);
        rst     = 1'b0;
        dm_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
        chk("t5_after_ack", 32'(dm_ack), 32'd0);

        // DM request arriving during an IF transaction
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        tick();
        chk("t6_c1_addr", bus_addr, 32'h0000_0010);
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_sel   = 4'hC;
        dm_addr  = 32'h0000_0400;
        dm_wdata = 32'h0000_0055;
        #1;
        chk("t6_c1_stall_mem", 32'(stallreq_mem), 32'd1);
        tick();
        chk("t6_c2_stall_mem", 32'(stallreq_mem), 32'd1);
        chk("t6_c2_addr",      bus_addr,          32'h0000_0010);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
        tick();
        chk("t6_c3_if_ack",    32'(if_ack),       32'd1);
        chk("t6_c3_if_rd",     if_rdata,          32'h0BAD_F00D);
        chk("t6_c3_stb",       32'(bus_stb),      32'd0);
        chk("t6_c3_stall_mem", 32'(stallreq_mem), 32'd1);
        if_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
        chk("t6_c4_stb",       32'(bus_stb),      32'd1);
        chk("t6_c4_addr",      bus_addr,          32'h0000_0400);
        chk("t6_c4_we",        32'(bus_we),       32'd1);
        chk("t6_c4_sel",       32'(bus_sel),      32'hC);
        chk("t6_c4_wdata",     bus_wdata,         32'h0000_0055);
        chk("t6_c4_stall_mem", 32'(stallreq_mem), 32'd1);
        bus_ack = 1'b1;
        tick();
        chk("t6_c5_dm_ack",    32'(dm_ack),       32'd1);
        chk("t6_c5_dm_rd",     dm_rdata,          32'd0);
        chk("t6_c5_stall_mem", 32'(stallreq_mem), 32'd0);
        dm_req  = 1'b0;
        bus_ack = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares one external memory bus between the instruction-fetch port (driven by `pc_reg`/`if_id`) and the data port (driven by the `mem` stage). It schedules the two requesters round-robin. It runs one bus transaction at a time with a registered req/ack handshake, returns read data and completion pulses, and raises stall requests toward the pipeline controller while a requester is waiting. A timeout counter aborts transactions the slave never acknowledges.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: bus cycles allowed per transaction before abort; range 1..255 (8-bit counter).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ack`.
- `if_addr`  in  32  fetch word address.
- `if_rdata`  out  32  fetched instruction, valid while `if_ack`=1.
- `if_ack`  out  1  one-cycle completion pulse for fetch.
- `stallreq_if`  out  1  `if_req & ~if_ack`.
- `dm_req`  in  1  data request; held with its qualifiers until `dm_ack`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_sel`  in  4  byte enables.
- `dm_addr`  in  32  data address.
- `dm_wdata`  in  32  store data.
- `dm_rdata`  out  32  load data, valid while `dm_ack`=1.
- `dm_ack`  out  1  one-cycle completion pulse for data.
- `stallreq_mem`  out  1  `dm_req & ~dm_ack`.
- `bus_cyc`, `bus_stb`  out  1  transaction active (both equal, registered).
- `bus_we`  out  1  write strobe.
- `bus_sel`  out  4  byte enables.
- `bus_addr`  out  32  address.
- `bus_wdata`  out  32  write data.
- `bus_rdata`  in  32  slave read data.
- `bus_ack`  in  1  slave completion, sampled only while `bus_stb`=1.
- `timeout_o`  out  1  one-cycle pulse when a transaction is aborted.

## Operation
- FSM has three states: `IDLE`, `BUSY_IF`, `BUSY_DM`. The granted owner is encoded by the state. `last_grant` is a 1-bit register: 0 = IF, 1 = DM.
- IDLE arbitration, evaluated on each edge:
  - Only one port requesting: grant that port.
  - Both requesting: grant the port not in `last_grant`.
  - Neither requesting: stay in IDLE.
- On grant, register the bus outputs and the owner, set `last_grant` to the owner, clear the counter, and move to BUSY_x.
- IF grant drives `bus_we`=0, `bus_sel`=4'b1111, `bus_addr`=`if_addr`.
- DM grant drives `dm_we`, `dm_sel`, `dm_addr` and `dm_wdata` onto the bus.
- In BUSY_x with `bus_ack`=1:
  - Capture `bus_rdata` into `x_rdata`. For a write, capture 0 instead.
  - Pulse `x_ack` in the next cycle.
  - Drop `bus_cyc`/`bus_stb` and return to IDLE.
- In BUSY_x with no ack, the counter increments. When it reaches `TIMEOUT_CYCLES`:
  - Abort: drop the bus, set `x_rdata`=0, and pulse `x_ack` and `timeout_o` together.
  - Return to IDLE.
- `x_rdata` holds its value after the ack pulse until the next completion on the same port.
- In the `x_ack` cycle the FSM is already in IDLE. A request still asserted in that cycle is treated as a new request.
- Requests arriving while BUSY wait. Their `stallreq_*` stays high, and the request is arbitrated at the next IDLE.
- Address width is 32 bits with no alignment checks; misaligned addresses pass through unchanged.

## Timing
- Reset values:
  - state IDLE; `last_grant`=0; counter=0.
  - `bus_cyc`=`bus_stb`=`bus_we`=0; `bus_sel`=0; `bus_addr`=`bus_wdata`=0.
  - `if_rdata`=`dm_rdata`=0; `if_ack`=`dm_ack`=`timeout_o`=0.
- Minimum latency: request sampled at edge k → `bus_stb`=1 in cycle k+1 → slave acks in cycle k+1 → `x_ack`=1 in cycle k+2. Minimum cost is 2 cycles per transaction, with IDLE overlapping the ack cycle.
- Slave acking n cycles after the first `bus_stb` cycle: `x_ack` arrives at cycle k+2+n.
- Timeout: `bus_stb` stays high for exactly `TIMEOUT_CYCLES` cycles, then `x_ack` and `timeout_o` pulse in the following cycle.
- Back-to-back requests from both ports alternate IF, DM, IF, ... with one bus-idle cycle between transactions.
- `stallreq_*` are combinational from `x_req` and the registered `x_ack`. They fall in the same cycle as the ack.
- Reset mid-transaction: `bus_cyc`/`bus_stb` are 0 in the cycle after the reset edge. No `x_ack` or `timeout_o` is issued, and any in-flight `bus_ack` is ignored.
- A `bus_ack` seen while `bus_stb`=0 is ignored.

## Test plan
- IF read, slave acks immediately: `if_req`=1, `if_addr`=0x0000_0004 at edge 0 → `bus_stb`=1 with `bus_addr`=0x4 and `bus_sel`=0xF in cycle 1 → `if_ack`=1 with `if_rdata`=`bus_rdata`=0x3401_1100 in cycle 2. `stallreq_if` is 1 in cycles 0–1 and 0 in cycle 2.
- DM write with 3 wait cycles: `dm_we`=1, `dm_sel`=4'b0011, `dm_addr`=0x100, `dm_wdata`=0xDEAD_BEEF → bus carries these values for 4 cycles. `dm_ack` pulses one cycle after `bus_ack`, and `dm_rdata`=0.
- Simultaneous requests from reset, both held: grants go DM, then IF, then DM (`last_grant` reset value 0). A one-cycle bus-idle gap separates each grant.
- Timeout with `TIMEOUT_CYCLES`=4 and `bus_ack` tied 0 → `bus_stb` is high exactly 4 cycles, then `if_ack`=`timeout_o`=1 for one cycle with `if_rdata`=0, and the FSM returns to IDLE.
- `rst`=1 asserted in the second BUSY_DM cycle while the slave acks in the same cycle → all outputs are at reset values on the next cycle and no `dm_ack` is issued.
- DM request arriving during an IF transaction → `stallreq_mem`=1 throughout. The DM grant occurs in the `if_ack` cycle, with `bus_stb` high for DM in the following cycle.
